audio_adc_receiver: RTL

//  Serial-to-parallel receiver for the codec ADC path: AUD_ADCDAT/AUD_ADCLRCK/AUD_BCLK in, stereo

---
 rtl/audio_adc_receiver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/audio_adc_receiver.sv
// Codec ADC serial receiver: oversamples BCLK/LRCK/DAT on Clk, deserializes I2S or
// left-justified frames and presents stereo pairs on a valid/ready handshake.
module audio_adc_receiver #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          I2S_MODE    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] LDATA,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  short_err
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CntLast = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSkip, StShift, StWait} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic                   bclk_prev_q, lrck_prev_q;
  logic                   bclk_s, lrck_s, dat_s, bclk_rise, lr_edge;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d, shifted, word_val;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   chan_q, chan_d;
  logic                   word_done, short_pulse, start_ch;
  logic [DATA_WIDTH-1:0]  pend_l_q, commit_l_q, commit_r_q;
  logic                   pend_v_q, commit_q;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lr_edge   = lrck_s ^ lrck_prev_q;
  assign shifted   = {shift_q[DATA_WIDTH-2:0], dat_s};

  // Pin synchronizers and BCLK edge history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev_q <= bclk_s;
    end
  end

  // Deserializer next state; everything moves only on a BCLK rise.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    chan_d      = chan_q;
    word_done   = 1'b0;
    word_val    = '0;
    short_pulse = 1'b0;
    start_ch    = 1'b0;
    if (bclk_rise) begin
      unique case (state_q)
        StIdle: begin
          // Only a 1->0 edge starts, so the first pair is a whole left then right.
          if (lr_edge && !lrck_s) start_ch = 1'b1;
        end
        StSkip, StShift: begin
          if (lr_edge) begin
            short_pulse = 1'b1;
            start_ch    = 1'b1;
            // A channel that never reached its MSB yields no word.
            if (state_q == StShift) begin
              word_done = 1'b1;
              word_val  = shift_q << (DATA_WIDTH - 32'(cnt_q));
            end
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
            state_d = StShift;
            if (cnt_q == CntLast) begin
              word_done = 1'b1;
              word_val  = shifted;
              state_d   = StWait;
            end
          end
        end
        StWait: begin
          if (lr_edge) start_ch = 1'b1;
        end
        default: state_d = StIdle;
      endcase
      if (start_ch) begin
        chan_d = lrck_s;
        if (I2S_MODE) begin
          // The edge rise carries the previous word's LSB; MSB follows on the next rise.
          state_d = StSkip;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = StShift;
          shift_d = {{(DATA_WIDTH - 1){1'b0}}, dat_s};
          cnt_d   = CW'(1);
        end
      end
    end
  end

  // Deserializer state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      chan_q      <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      if (bclk_rise) lrck_prev_q <= lrck_s;
    end
  end

  // Pair assembly: park left words, commit on a right word that has a left partner.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_l_q   <= '0;
      pend_v_q   <= 1'b0;
      commit_q   <= 1'b0;
      commit_l_q <= '0;
      commit_r_q <= '0;
      short_err  <= 1'b0;
    end else begin
      commit_q  <= 1'b0;
      short_err <= short_pulse;
      if (word_done) begin
        if (!chan_q) begin
          pend_l_q <= word_val;
          pend_v_q <= 1'b1;
        end else if (pend_v_q) begin
          commit_q   <= 1'b1;
          commit_l_q <= pend_l_q;
          commit_r_q <= word_val;
          pend_v_q   <= 1'b0;
        end
      end
    end
  end

  // Holding register and handshake; a commit into an unaccepted pair is dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      LDATA        <= '0;
      RDATA        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_q) begin
        if (!sample_valid || sample_ready) begin
          LDATA        <= commit_l_q;
          RDATA        <= commit_r_q;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
